// File: rtl/fifo_pkg.sv
// Shared definitions for the asyfifo read-side drain engine: default widths,
// drain FSM state type, debug snapshot struct and the skid credit helper.
package fifo_pkg;

  localparam int FIFO_WIDTH     = 8;
  localparam int FIFO_CNT_WIDTH = 16;
  localparam int SKID_DEPTH     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } drain_state_e;

  typedef struct packed {
    drain_state_e state;
    logic [1:0]   occ;
    logic         pending;
  } drain_dbg_t;

  // Space check for one more read: words held plus in flight minus the one
  // leaving this cycle must stay below the skid depth. Evaluated at 3 bits.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       pending,
                                     input logic       pop);
    logic [2:0] sum;
    sum = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
    return sum < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry in-order skid buffer; entry 0 is always the oldest word and
// drives the output, so the head only moves on a pop or a push into empty.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]       occ_q, occ_d;
  logic             pop_eff;

  assign pop_eff = pop_i && (occ_q != 2'd0);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    if (pop_eff && !push_i) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
    end else if (push_i && !pop_eff) begin
      // A push into a full buffer is dropped; the credit rule upstream
      // guarantees it never happens.
      if (occ_q == 2'd0) begin
        ent0_d = din_i;
      end else if (occ_q == 2'd1) begin
        ent1_d = din_i;
      end
      if (occ_q < 2'(SKID_DEPTH)) begin
        occ_d = occ_q + 2'd1;
      end
    end else if (push_i && pop_eff) begin
      if (occ_q == 2'd2) begin
        ent0_d = ent1_q;
        ent1_d = din_i;
      end else begin
        ent0_d = din_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign dout_o = ent0_q;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Flow-controlled read-side consumer for asyfifo: issues reads only with
// guaranteed skid space. Define FIFO_RD_CNT_EN to add word_cnt/err_cnt.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int CNT_WIDTH = FIFO_CNT_WIDTH
) (
  input  logic                 rd_clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_r_data,
  input  logic                 fifo_rd_err,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  output logic [WIDTH-1:0]     m_data,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 err,
`ifdef FIFO_RD_CNT_EN
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
`endif
  output drain_dbg_t           dbg
);

  if (WIDTH < 1 || CNT_WIDTH < 1) begin : g_param_chk
    $error("fifo_rd_drain: WIDTH and CNT_WIDTH must be positive");
  end

  drain_state_e state_q;
  logic         busy_q;
  logic         pending_q;
  logic         err_q;
  logic [1:0]   occ;
  logic         pop;
  logic         rd_en;

  // Handshake: a word transfers in every cycle where m_valid && m_ready;
  // m_valid never drops and m_data never changes until that happens.
  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  // en is gated directly so a falling en blocks reads in that same cycle.
  assign rd_en = (state_q == ST_RUN) && en && !fifo_empty &&
                 credit_ok(occ, pending_q, pop);

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= rd_en;
      if (fifo_rd_err) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (en) begin
            state_q <= ST_RUN;
          end else if (!pending_q && (occ == 2'd0)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk    (rd_clk),
    .rst_n  (rst_n),
    .push_i (pending_q),
    .din_i  (fifo_r_data),
    .pop_i  (pop),
    .dout_o (m_data),
    .occ_o  (occ)
  );

`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] word_cnt_q;
  logic [CNT_WIDTH-1:0] err_cnt_q;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (pop) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
      if (fifo_rd_err) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign word_cnt = word_cnt_q;
  assign err_cnt  = err_cnt_q;
`endif

  assign fifo_rd_en = rd_en;
  assign busy       = busy_q;
  assign err        = err_q;
  assign dbg        = '{state: state_q, occ: occ, pending: pending_q};

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench for fifo_rd_drain: a queue-based FIFO model feeds the DUT and a
// scoreboard checks delivered order, latency, stalls and status outputs.
module tb_fifo_rd_drain;
  import fifo_pkg::*;

  logic       rd_clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_r_data;
  logic       fifo_rd_err;
  logic       fifo_rd_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       busy;
  logic       err;
`ifdef FIFO_RD_CNT_EN
  logic [15:0] word_cnt;
  logic [15:0] err_cnt;
`endif
  drain_dbg_t dbg;

  // clock / reset
  always #5 rd_clk = ~rd_clk;

  fifo_rd_drain #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .rd_clk      (rd_clk),
    .rst_n       (rst_n),
    .en          (en),
    .fifo_empty  (fifo_empty),
    .fifo_r_data (fifo_r_data),
    .fifo_rd_err (fifo_rd_err),
    .fifo_rd_en  (fifo_rd_en),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_ready     (m_ready),
    .busy        (busy),
    .err         (err),
`ifdef FIFO_RD_CNT_EN
    .word_cnt    (word_cnt),
    .err_cnt     (err_cnt),
`endif
    .dbg         (dbg)
  );

  // reference model state
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rd_word;
  logic [7:0] prev_data;
  bit         rd_pend;
  bit         prev_stall;
  int         n_tests;
  int         n_fail;
  int         cyc;
  int         rx_cnt;
  int         first_rd;
  int         first_v;
  int         first_pop;
  int         last_pop;
  int         err_ref;

  always @(negedge rd_clk) begin
    if (rst_n) begin
      assert (!(dbg.occ == 2'd2 && dbg.pending && !(m_valid && m_ready)))
        else $error("skid buffer overflow attempt");
      assert (dbg.occ <= 2'd2) else $error("skid occupancy out of range");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    rd_pend    = 1'b0;
    prev_stall = 1'b0;
    rx_cnt     = 0;
    first_rd   = -1;
    first_v    = -1;
    first_pop  = -1;
    last_pop   = -1;
    err_ref    = 0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    en          = 1'b0;
    m_ready     = 1'b0;
    fifo_rd_err = 1'b0;
    fifo_empty  = 1'b1;
    clear_model();
    @(posedge rd_clk);
    @(posedge rd_clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic fifo_write(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic monitor();
    logic [7:0] e;
    if (fifo_empty) check("rd_en_while_empty", fifo_rd_en, 1'b0);
    if (prev_stall) begin
      check("hold_valid", m_valid, 1'b1);
      check("hold_data", m_data, prev_data);
    end
    if (m_valid && first_v < 0) first_v = cyc;
    if (m_valid && m_ready) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : ~m_data;
      check("rx_data", m_data, e);
      rx_cnt++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (fifo_rd_en) begin
      if (first_rd < 0) first_rd = cyc;
      if (fifo_q.size() != 0) begin
        rd_word = fifo_q.pop_front();
        rd_pend = 1'b1;
      end
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
  endtask

  // driver: one rd_clk cycle, inputs applied 1 after the edge, sampled at +4
  task automatic tick(input logic en_v, input logic rdy_v, input logic err_v);
    @(posedge rd_clk);
    #1;
    cyc++;
    fifo_r_data = rd_pend ? rd_word : 8'($urandom);
    rd_pend     = 1'b0;
    fifo_empty  = (fifo_q.size() == 0);
    en          = en_v;
    m_ready     = rdy_v;
    fifo_rd_err = err_v;
    if (err_v) err_ref++;
    #3;
    monitor();
  endtask

  initial begin
    int gap;
    int wr_left;
    int n_err;
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b1;
    en      = 1'b0;
    m_ready = 1'b0;
    fifo_rd_err = 1'b0;
    fifo_empty  = 1'b1;
    fifo_r_data = 8'h00;
    clear_model();

    // reset values and idle with data waiting
    #1 rst_n = 1'b0;
    #2;
    check("rst_rd_en", fifo_rd_en, 1'b0);
    check("rst_valid", m_valid, 1'b0);
    check("rst_data", m_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", dbg.state, ST_IDLE);
    check("rst_occ", dbg.occ, 2'd0);
    check("rst_pending", dbg.pending, 1'b0);
`ifdef FIFO_RD_CNT_EN
    check("rst_word_cnt", word_cnt, 16'd0);
    check("rst_err_cnt", err_cnt, 16'd0);
`endif
    do_reset();
    for (int i = 0; i < 5; i++) fifo_write(8'($urandom));
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      check("idle_rd_en", fifo_rd_en, 1'b0);
      check("idle_valid", m_valid, 1'b0);
      check("idle_busy", busy, 1'b0);
    end
    check("idle_fifo_untouched", fifo_q.size(), 5);

    // burst of 16 words with m_ready high
    do_reset();
    for (int i = 1; i <= 16; i++) fifo_write(8'(i));
    for (int i = 0; i < 60 && rx_cnt < 16; i++) tick(1'b1, 1'b1, 1'b0);
    check("burst_count", rx_cnt, 16);
    check("burst_latency", first_v - first_rd, 2);
    check("burst_b2b", last_pop - first_pop, 15);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
    check("burst_busy", busy, 1'b1);
`ifdef FIFO_RD_CNT_EN
    check("burst_word_cnt", word_cnt, 16'd16);
`endif
    for (int i = 0; i < 10 && busy; i++) tick(1'b0, 1'b1, 1'b0);
    check("burst_idle_busy", busy, 1'b0);
    check("burst_idle_state", dbg.state, ST_IDLE);

    // backpressure: m_ready toggles every 3 cycles
    do_reset();
    for (int i = 0; i < 16; i++) fifo_write(8'($urandom));
    for (int k = 0; k < 200 && rx_cnt < 16; k++) tick(1'b1, ((k / 3) % 2) == 0, 1'b0);
    check("bp_count", rx_cnt, 16);
    check("bp_left", exp_q.size(), 0);
`ifdef FIFO_RD_CNT_EN
    check("bp_word_cnt", word_cnt, 16'd16);
`endif

    // drain stop right after the first read, then ragged en
    do_reset();
    for (int i = 0; i < 10; i++) fifo_write(8'($urandom));
    for (int i = 0; i < 10 && first_rd < 0; i++) tick(1'b1, 1'b1, 1'b0);
    check("stop_read_seen", first_rd >= 0, 1'b1);
    for (int i = 0; i < 20 && (busy || i < 2); i++) tick(1'b0, 1'b1, 1'b0);
    check("stop_delivered", rx_cnt, 1);
    check("stop_busy", busy, 1'b0);
    check("stop_state", dbg.state, ST_IDLE);
    check("stop_unread", fifo_q.size(), 9);
    for (int i = 0; i < 400 && rx_cnt < 10; i++) tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("reen_count", rx_cnt, 10);

    // concurrent writes at random gaps, random m_ready
    do_reset();
    wr_left = 200;
    gap = $urandom_range(1, 8);
    for (int i = 0; i < 5000 && rx_cnt < 200; i++) begin
      tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      if (wr_left > 0) begin
        gap--;
        if (gap == 0) begin
          fifo_write(8'($urandom));
          wr_left--;
          gap = $urandom_range(1, 8);
        end
      end
    end
    check("conc_count", rx_cnt, 200);
    check("conc_left", exp_q.size(), 0);
    check("conc_err", err, 1'b0);
`ifdef FIFO_RD_CNT_EN
    check("conc_err_cnt", err_cnt, 16'd0);
    check("conc_word_cnt", word_cnt, 16'd200);
`endif

    // rd_err pulses: sticky err, FSM keeps running
    n_err = $urandom_range(2, 5);
    for (int i = 0; i < n_err; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
    check("err_sticky", err, 1'b1);
    check("err_state", dbg.state, ST_RUN);
`ifdef FIFO_RD_CNT_EN
    check("err_cnt", err_cnt, 16'(err_ref));
`endif

    // reset with the buffer full
    do_reset();
    for (int i = 0; i < 16; i++) fifo_write(8'($urandom));
    for (int i = 0; i < 10 && dbg.occ != 2'd2; i++) tick(1'b1, 1'b0, 1'b0);
    check("mid_occ_full", dbg.occ, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rd_en", fifo_rd_en, 1'b0);
    check("mid_valid", m_valid, 1'b0);
    check("mid_data", m_data, 8'h00);
    check("mid_busy", busy, 1'b0);
    check("mid_occ", dbg.occ, 2'd0);
    check("mid_pending", dbg.pending, 1'b0);
    check("mid_state", dbg.state, ST_IDLE);
`ifdef FIFO_RD_CNT_EN
    check("mid_word_cnt", word_cnt, 16'd0);
`endif
    clear_model();
    @(posedge rd_clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    check("post_state", dbg.state, ST_IDLE);
    check("post_valid", m_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
